// File: rtl/usb_rx_pkt_decoder.sv
// usb_rx_pkt_decoder: USB 2.0 packet-level receive decoder behind the ULPI RX
// stream. Checks PID/length/CRC5/CRC16 and splits tokens, SOF, handshakes, data.
// Ports: ulpi_clk/ulpi_rst_n (async active-low); rx_t* input stream (never
//   back-pressured); tok_*, sof_*, hs_* pulses; out_t* payload stream;
//   data_done/pid/len/crc_ok per data packet; err_valid/err_code per packet.
// Option: define USB_RX_CRC_STRIP_EN to hold back 2 bytes and strip CRC16
//   from out_*; otherwise every post-PID byte (CRC included) is forwarded.
module usb_rx_pkt_decoder #(
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic        ulpi_clk,
    input  logic        ulpi_rst_n,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tlast,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic        tok_valid,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic        sof_valid,
    output logic [10:0] sof_frame,
    output logic        hs_valid,
    output logic [3:0]  hs_pid,
    output logic [7:0]  out_tdata,
    output logic        out_tvalid,
    output logic        out_tlast,
    output logic        data_done,
    output logic [3:0]  data_pid,
    output logic [10:0] data_len,
    output logic        data_crc_ok,
    output logic        err_valid,
    output logic [2:0]  err_code
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TOKEN = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    // Highest post-PID byte count that still fits payload + CRC16.
    localparam logic [11:0] CNT_MAX   = 12'(MAX_PAYLOAD + 2);
    localparam logic [4:0]  CRC5_RES  = 5'b01100;
    localparam logic [15:0] CRC16_RES = 16'h800D;

    function automatic logic [4:0] crc5_byte(logic [4:0] c, logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(logic [15:0] c, logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        tidx_q, tidx_d;
    logic [7:0]  b1_q, b1_d;
    logic [3:0]  tpid_q, tpid_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic [11:0] cnt_q, cnt_d;
    logic        tokv_q, tokv_d, sofv_q, sofv_d, hsv_q, hsv_d;
    logic [3:0]  tokp_q, tokp_d, hsp_q, hsp_d, dpid_q, dpid_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;
    logic [10:0] frame_q, frame_d, dlen_q, dlen_d;
    logic [7:0]  odata_q, odata_d;
    logic        ovalid_q, ovalid_d, olast_q, olast_d;
    logic        done_q, done_d, crcok_q, crcok_d;
    logic        errv_q, errv_d;
    logic [2:0]  errc_q, errc_d;
`ifdef USB_RX_CRC_STRIP_EN
    logic [7:0]  h0_q, h0_d, h1_q, h1_d;
`endif

    logic [3:0]  pid;
    logic        pid_ok, is_tok, is_hs, is_data;
    logic [4:0]  c5;
    logic [15:0] c16;
    logic [11:0] cnt_inc;

    assign pid     = rx_tdata[3:0];
    assign pid_ok  = (rx_tdata[7:4] == ~rx_tdata[3:0]);
    assign is_tok  = pid inside {4'b0001, 4'b1001, 4'b1101, 4'b0100, 4'b0101};
    assign is_hs   = pid inside {4'b0010, 4'b1010, 4'b1110, 4'b0110};
    assign is_data = pid inside {4'b0011, 4'b1011, 4'b0111, 4'b1111};
    assign c5      = crc5_byte(crc5_q, rx_tdata);
    assign c16     = crc16_byte(crc16_q, rx_tdata);
    assign cnt_inc = cnt_q + 12'd1;

    always_comb begin
        state_d  = state_q;
        tidx_d   = tidx_q;
        b1_d     = b1_q;
        tpid_d   = tpid_q;
        crc5_d   = crc5_q;
        crc16_d  = crc16_q;
        cnt_d    = cnt_q;
        tokv_d   = 1'b0;
        tokp_d   = tokp_q;
        addr_d   = addr_q;
        endp_d   = endp_q;
        sofv_d   = 1'b0;
        frame_d  = frame_q;
        hsv_d    = 1'b0;
        hsp_d    = hsp_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        olast_d  = 1'b0;
        done_d   = 1'b0;
        dpid_d   = dpid_q;
        dlen_d   = dlen_q;
        crcok_d  = crcok_q;
        errv_d   = 1'b0;
        errc_d   = errc_q;
`ifdef USB_RX_CRC_STRIP_EN
        h0_d     = h0_q;
        h1_d     = h1_q;
`endif
        if (rx_tvalid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!pid_ok) begin
                        errv_d = 1'b1;
                        errc_d = 3'd1;
                        if (!rx_tlast) state_d = S_DROP;
                    end else if (is_tok) begin
                        if (rx_tlast) begin
                            errv_d = 1'b1;
                            errc_d = 3'd3;
                        end else begin
                            state_d = S_TOKEN;
                            tidx_d  = 1'b0;
                            tpid_d  = pid;
                            crc5_d  = 5'h1F;
                        end
                    end else if (is_hs) begin
                        if (rx_tlast) begin
                            hsv_d = 1'b1;
                            hsp_d = pid;
                        end else begin
                            errv_d  = 1'b1;
                            errc_d  = 3'd3;
                            state_d = S_DROP;
                        end
                    end else if (is_data) begin
                        dpid_d = pid;
                        if (rx_tlast) begin
                            errv_d  = 1'b1;
                            errc_d  = 3'd3;
                            done_d  = 1'b1;
                            dlen_d  = 11'd0;
                            crcok_d = 1'b0;
                        end else begin
                            state_d = S_DATA;
                            cnt_d   = 12'd0;
                            crc16_d = 16'hFFFF;
                        end
                    end else begin
                        errv_d = 1'b1;
                        errc_d = 3'd2;
                        if (!rx_tlast) state_d = S_DROP;
                    end
                end
                S_TOKEN: begin
                    crc5_d = c5;
                    if (!tidx_q) begin
                        b1_d   = rx_tdata;
                        tidx_d = 1'b1;
                        if (rx_tlast) begin
                            errv_d  = 1'b1;
                            errc_d  = 3'd3;
                            state_d = S_IDLE;
                        end
                    end else if (!rx_tlast) begin
                        errv_d  = 1'b1;
                        errc_d  = 3'd3;
                        state_d = S_DROP;
                    end else begin
                        state_d = S_IDLE;
                        if (c5 != CRC5_RES) begin
                            errv_d = 1'b1;
                            errc_d = 3'd4;
                        end else if (tpid_q == 4'b0101) begin
                            sofv_d  = 1'b1;
                            frame_d = {rx_tdata[2:0], b1_q};
                        end else begin
                            tokv_d = 1'b1;
                            tokp_d = tpid_q;
                            addr_d = b1_q[6:0];
                            endp_d = {rx_tdata[2:0], b1_q[7]};
                        end
                    end
                end
                S_DATA: begin
                    cnt_d   = cnt_inc;
                    crc16_d = c16;
                    if (cnt_inc > CNT_MAX) begin
                        errv_d  = 1'b1;
                        errc_d  = 3'd5;
                        state_d = rx_tlast ? S_IDLE : S_DROP;
                    end else begin
`ifdef USB_RX_CRC_STRIP_EN
                        // Two-byte delay: the last two bytes are the CRC.
                        h0_d = rx_tdata;
                        h1_d = h0_q;
                        if (cnt_inc >= 12'd3) begin
                            ovalid_d = 1'b1;
                            odata_d  = h1_q;
                            olast_d  = rx_tlast;
                        end
`else
                        ovalid_d = 1'b1;
                        odata_d  = rx_tdata;
                        olast_d  = rx_tlast;
`endif
                        if (rx_tlast) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            if (cnt_inc < 12'd2) begin
                                errv_d  = 1'b1;
                                errc_d  = 3'd3;
                                dlen_d  = 11'd0;
                                crcok_d = 1'b0;
                            end else begin
                                dlen_d  = 11'(cnt_inc - 12'd2);
                                crcok_d = (c16 == CRC16_RES);
                                if (c16 != CRC16_RES) begin
                                    errv_d = 1'b1;
                                    errc_d = 3'd6;
                                end
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (rx_tlast) state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            state_q  <= S_IDLE;
            tidx_q   <= 1'b0;
            b1_q     <= '0;
            tpid_q   <= '0;
            crc5_q   <= '0;
            crc16_q  <= '0;
            cnt_q    <= '0;
            tokv_q   <= 1'b0;
            tokp_q   <= '0;
            addr_q   <= '0;
            endp_q   <= '0;
            sofv_q   <= 1'b0;
            frame_q  <= '0;
            hsv_q    <= 1'b0;
            hsp_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            done_q   <= 1'b0;
            dpid_q   <= '0;
            dlen_q   <= '0;
            crcok_q  <= 1'b0;
            errv_q   <= 1'b0;
            errc_q   <= '0;
`ifdef USB_RX_CRC_STRIP_EN
            h0_q     <= '0;
            h1_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tidx_q   <= tidx_d;
            b1_q     <= b1_d;
            tpid_q   <= tpid_d;
            crc5_q   <= crc5_d;
            crc16_q  <= crc16_d;
            cnt_q    <= cnt_d;
            tokv_q   <= tokv_d;
            tokp_q   <= tokp_d;
            addr_q   <= addr_d;
            endp_q   <= endp_d;
            sofv_q   <= sofv_d;
            frame_q  <= frame_d;
            hsv_q    <= hsv_d;
            hsp_q    <= hsp_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            done_q   <= done_d;
            dpid_q   <= dpid_d;
            dlen_q   <= dlen_d;
            crcok_q  <= crcok_d;
            errv_q   <= errv_d;
            errc_q   <= errc_d;
`ifdef USB_RX_CRC_STRIP_EN
            h0_q     <= h0_d;
            h1_q     <= h1_d;
`endif
        end
    end

    // Never back-pressure; low only while reset is held.
    assign rx_tready   = ulpi_rst_n;
    assign tok_valid   = tokv_q;
    assign tok_pid     = tokp_q;
    assign tok_addr    = addr_q;
    assign tok_endp    = endp_q;
    assign sof_valid   = sofv_q;
    assign sof_frame   = frame_q;
    assign hs_valid    = hsv_q;
    assign hs_pid      = hsp_q;
    assign out_tdata   = odata_q;
    assign out_tvalid  = ovalid_q;
    assign out_tlast   = olast_q;
    assign data_done   = done_q;
    assign data_pid    = dpid_q;
    assign data_len    = dlen_q;
    assign data_crc_ok = crcok_q;
    assign err_valid   = errv_q;
    assign err_code    = errc_q;

endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// Testbench for usb_rx_pkt_decoder: directed packets plus random packets
// scored against a packet-level reference model (honours USB_RX_CRC_STRIP_EN).
module tb_usb_rx_pkt_decoder;
    localparam int MAXP = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rx_tdata;
    logic rx_tlast, rx_tvalid, rx_tready;
    logic tok_valid, sof_valid, hs_valid;
    logic [3:0] tok_pid, tok_endp, hs_pid, data_pid;
    logic [6:0] tok_addr;
    logic [10:0] sof_frame, data_len;
    logic [7:0] out_tdata;
    logic out_tvalid, out_tlast, data_done, data_crc_ok, err_valid;
    logic [2:0] err_code;

    usb_rx_pkt_decoder #(.MAX_PAYLOAD(MAXP)) dut (
        .ulpi_clk(clk), .ulpi_rst_n(rst_n),
        .rx_tdata(rx_tdata), .rx_tlast(rx_tlast),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .tok_valid(tok_valid), .tok_pid(tok_pid),
        .tok_addr(tok_addr), .tok_endp(tok_endp),
        .sof_valid(sof_valid), .sof_frame(sof_frame),
        .hs_valid(hs_valid), .hs_pid(hs_pid),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid),
        .out_tlast(out_tlast), .data_done(data_done),
        .data_pid(data_pid), .data_len(data_len),
        .data_crc_ok(data_crc_ok),
        .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int last_st = 0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic [7:0] pkt[$];
    logic [7:0] pk2[$];
    logic bq[$];

    function automatic logic [63:0] ev(logic [3:0] k, logic [27:0] p, int st);
        return {k, p, 32'(st)};
    endfunction
    function automatic logic [63:0] e_tok(logic [3:0] p, logic [6:0] a,
                                          logic [3:0] e, int st);
        return ev(4'd1, {13'd0, p, a, e}, st);
    endfunction
    function automatic logic [63:0] e_sof(logic [10:0] f, int st);
        return ev(4'd2, {17'd0, f}, st);
    endfunction
    function automatic logic [63:0] e_hs(logic [3:0] p, int st);
        return ev(4'd3, {24'd0, p}, st);
    endfunction
    function automatic logic [63:0] e_out(logic [7:0] d, logic l);
        return ev(4'd4, {19'd0, l, d}, 0);
    endfunction
    function automatic logic [63:0] e_done(logic [3:0] p, logic [10:0] n,
                                           logic ok, int st);
        return ev(4'd5, {12'd0, p, n, ok}, st);
    endfunction
    function automatic logic [63:0] e_err(logic [2:0] c);
        return ev(4'd6, {25'd0, c}, 0);
    endfunction

    // Output event log, one fixed order within a cycle.
    always @(negedge clk) begin
        if (out_tvalid) obs_q.push_back(e_out(out_tdata, out_tlast));
        if (data_done)
            obs_q.push_back(e_done(data_pid, data_len, data_crc_ok, cyc));
        if (err_valid) obs_q.push_back(e_err(err_code));
        if (tok_valid)
            obs_q.push_back(e_tok(tok_pid, tok_addr, tok_endp, cyc));
        if (sof_valid) obs_q.push_back(e_sof(sof_frame, cyc));
        if (hs_valid) obs_q.push_back(e_hs(hs_pid, cyc));
    end

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check(input string tag);
        chk({tag, " count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s ev%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Generic serial CRC over bq (first-transmitted bit first).
    function automatic logic [15:0] crc_run(int w, logic [15:0] poly,
                                            logic [15:0] init);
        logic [15:0] r, mask;
        logic msb;
        mask = (16'd1 << w) - 16'd1;
        r = init;
        foreach (bq[i]) begin
            msb = r[w-1];
            r = (r << 1) & mask;
            if (msb ^ bq[i]) r = r ^ poly;
        end
        return r & mask;
    endfunction

    task automatic pack_bits();
        logic [7:0] b;
        for (int i = 0; i + 7 < bq.size(); i += 8) begin
            for (int j = 0; j < 8; j++) b[j] = bq[i+j];
            pkt.push_back(b);
        end
    endtask

    task automatic gen_token(input logic [3:0] p, input logic [10:0] f,
                             input bit bad);
        logic [15:0] r;
        pkt.delete();
        bq.delete();
        pkt.push_back({~p, p});
        for (int i = 0; i < 11; i++) bq.push_back(f[i]);
        r = crc_run(5, 16'h0005, 16'h001F);
        for (int i = 4; i >= 0; i--) bq.push_back(~r[i]);
        if (bad) bq[$urandom_range(0, 15)] ^= 1'b1;
        pack_bits();
    endtask

    task automatic gen_data(input logic [3:0] p, input int len, input bit bad);
        logic [15:0] r;
        logic [7:0] d;
        pkt.delete();
        bq.delete();
        pkt.push_back({~p, p});
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            for (int j = 0; j < 8; j++) bq.push_back(d[j]);
        end
        r = crc_run(16, 16'h8005, 16'hFFFF);
        for (int i = 15; i >= 0; i--) bq.push_back(~r[i]);
        if (bad) bq[$urandom_range(0, bq.size() - 1)] ^= 1'b1;
        pack_bits();
    endtask

    // Reference model: expected events for one whole packet.
    task automatic model(input logic [7:0] p[$], input int st);
        int n, k;
        logic [3:0] pid;
        logic [15:0] r;
        n = p.size();
        pid = p[0][3:0];
        st = st + 1;
        if (p[0][7:4] != ~p[0][3:0]) begin
            exp_q.push_back(e_err(3'd1));
            return;
        end
        if (pid inside {4'h1, 4'h9, 4'hD, 4'h4, 4'h5}) begin
            if (n != 3) begin
                exp_q.push_back(e_err(3'd3));
                return;
            end
            bq.delete();
            for (int b = 1; b <= 2; b++)
                for (int j = 0; j < 8; j++) bq.push_back(p[b][j]);
            r = crc_run(5, 16'h0005, 16'h001F);
            if (r[4:0] != 5'b01100) exp_q.push_back(e_err(3'd4));
            else if (pid == 4'h5)
                exp_q.push_back(e_sof({p[2][2:0], p[1]}, st));
            else
                exp_q.push_back(e_tok(pid, p[1][6:0], {p[2][2:0], p[1][7]}, st));
        end else if (pid inside {4'h2, 4'hA, 4'hE, 4'h6}) begin
            if (n == 1) exp_q.push_back(e_hs(pid, st));
            else exp_q.push_back(e_err(3'd3));
        end else if (pid inside {4'h3, 4'hB, 4'h7, 4'hF}) begin
            k = n - 1;
            if (k > MAXP + 2) begin
`ifdef USB_RX_CRC_STRIP_EN
                for (int i = 1; i <= MAXP; i++) exp_q.push_back(e_out(p[i], 1'b0));
`else
                for (int i = 1; i <= MAXP + 2; i++)
                    exp_q.push_back(e_out(p[i], 1'b0));
`endif
                exp_q.push_back(e_err(3'd5));
                return;
            end
            if (k < 2) begin
`ifndef USB_RX_CRC_STRIP_EN
                for (int i = 1; i <= k; i++) exp_q.push_back(e_out(p[i], i == k));
`endif
                exp_q.push_back(e_done(pid, 11'd0, 1'b0, st));
                exp_q.push_back(e_err(3'd3));
                return;
            end
            bq.delete();
            for (int b = 1; b <= k; b++)
                for (int j = 0; j < 8; j++) bq.push_back(p[b][j]);
            r = crc_run(16, 16'h8005, 16'hFFFF);
`ifdef USB_RX_CRC_STRIP_EN
            for (int i = 1; i <= k - 2; i++)
                exp_q.push_back(e_out(p[i], i == k - 2));
`else
            for (int i = 1; i <= k; i++) exp_q.push_back(e_out(p[i], i == k));
`endif
            exp_q.push_back(e_done(pid, 11'(k - 2), r == 16'h800D, st));
            if (r != 16'h800D) exp_q.push_back(e_err(3'd6));
        end else begin
            exp_q.push_back(e_err(3'd2));
        end
    endtask

    task automatic send(input logic [7:0] p[$], input bit gaps);
        for (int i = 0; i < p.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                rx_tvalid = 1'b0;
                rx_tdata = 8'($urandom);
                rx_tlast = 1'($urandom);
            end
            @(negedge clk);
            rx_tvalid = 1'b1;
            rx_tdata = p[i];
            rx_tlast = (i == p.size() - 1);
            last_st = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_tvalid = 1'b0;
            rx_tlast = 1'b0;
            rx_tdata = 8'h00;
        end
    endtask

    task automatic chk_reset(input string tag);
        #1;
        chk({tag, " rdy"}, 64'(rx_tready), 64'd0);
        chk({tag, " pulses"}, 64'({tok_valid, sof_valid, hs_valid, out_tvalid,
            out_tlast, data_done, data_crc_ok, err_valid}), 64'd0);
        chk({tag, " fields"}, 64'({tok_pid, tok_addr, tok_endp, sof_frame,
            hs_pid, out_tdata, data_pid, data_len, err_code}), 64'd0);
    endtask

    task automatic build_random();
        logic [3:0] tokp[5];
        logic [3:0] hsp[4];
        logic [3:0] dp[4];
        logic [3:0] bp[3];
        int kind, len;
        tokp = '{4'h1, 4'h9, 4'hD, 4'h4, 4'h5};
        hsp = '{4'h2, 4'hA, 4'hE, 4'h6};
        dp = '{4'h3, 4'hB, 4'h7, 4'hF};
        bp = '{4'h0, 4'h8, 4'hC};
        kind = $urandom_range(0, 9);
        if (kind <= 2) begin
            gen_token(tokp[$urandom_range(0, 4)], 11'($urandom),
                      $urandom_range(0, 3) == 0);
            len = $urandom_range(0, 7);
            if (len == 0) void'(pkt.pop_back());
            if (len == 1) pkt.push_back(8'($urandom));
        end else if (kind == 3) begin
            pkt.delete();
            pkt.push_back({~hsp[$urandom_range(0, 3)], 4'h0});
            pkt[0][3:0] = ~pkt[0][7:4];
            if ($urandom_range(0, 3) == 0) pkt.push_back(8'($urandom));
        end else if (kind <= 7) begin
            if ($urandom_range(0, 7) == 0) len = $urandom_range(MAXP - 1, MAXP + 3);
            else len = $urandom_range(0, 12);
            gen_data(dp[$urandom_range(0, 3)], len, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0)
                while (pkt.size() > 2) void'(pkt.pop_back());
        end else begin
            pkt.delete();
            if (kind == 8) pkt.push_back(8'($urandom));
            else pkt.push_back({~bp[$urandom_range(0, 2)], 4'h0});
            if (kind == 9) pkt[0][3:0] = ~pkt[0][7:4];
            repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
        end
    endtask

    initial begin
        logic [7:0] d0[$];
        rx_tvalid = 1'b0;
        rx_tlast = 1'b0;
        rx_tdata = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        #1;
        chk("ready", 64'(rx_tready), 64'd1);
        idle(2);

        pkt = '{8'h2D, 8'h00, 8'h10};
        send(pkt, 0);
        exp_q.push_back(e_tok(4'hD, 7'd0, 4'd0, last_st + 1));
        idle(3);
        check("setup");

        pkt = '{8'h2D, 8'h00, 8'h11};
        send(pkt, 0);
        exp_q.push_back(e_err(3'd4));
        idle(3);
        check("setup_crc5");

        pkt = '{8'hD2};
        send(pkt, 0);
        exp_q.push_back(e_hs(4'h2, last_st + 1));
        idle(3);
        check("ack");

        pkt = '{8'hD2, 8'h00};
        send(pkt, 0);
        exp_q.push_back(e_err(3'd3));
        idle(3);
        check("ack_long");

        for (int f = 0; f < 2; f++) begin
            d0 = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
                   8'h40, 8'h00, 8'hDD, 8'h94};
            if (f == 1) d0[10] = 8'h95;
            send(d0, f == 1);
`ifdef USB_RX_CRC_STRIP_EN
            for (int i = 1; i <= 8; i++) exp_q.push_back(e_out(d0[i], i == 8));
`else
            for (int i = 1; i <= 10; i++) exp_q.push_back(e_out(d0[i], i == 10));
`endif
            exp_q.push_back(e_done(4'h3, 11'd8, f == 0, last_st + 1));
            if (f == 1) exp_q.push_back(e_err(3'd6));
            idle(3);
            check(f == 0 ? "data0" : "data0_crc16");
        end

        pkt = '{8'h4B, 8'h00, 8'h00};
        send(pkt, 0);
`ifndef USB_RX_CRC_STRIP_EN
        exp_q.push_back(e_out(8'h00, 1'b0));
        exp_q.push_back(e_out(8'h00, 1'b1));
`endif
        exp_q.push_back(e_done(4'hB, 11'd0, 1'b1, last_st + 1));
        idle(3);
        check("zlp");

        pkt = '{8'hC3};
        send(pkt, 0);
        exp_q.push_back(e_done(4'h3, 11'd0, 1'b0, last_st + 1));
        exp_q.push_back(e_err(3'd3));
        idle(3);
        check("data_short");

        pkt = '{8'hFF, 8'h12, 8'h34, 8'h56};
        send(pkt, 0);
        exp_q.push_back(e_err(3'd1));
        pkt = '{8'hD2};
        send(pkt, 0);
        exp_q.push_back(e_hs(4'h2, last_st + 1));
        idle(3);
        check("pid_err_then_ack");

        gen_data(4'h7, MAXP, 0);
        send(pkt, 1);
        model(pkt, last_st);
        idle(3);
        check("max_payload");

        gen_data(4'hF, MAXP + 1, 0);
        send(pkt, 0);
        model(pkt, last_st);
        idle(3);
        check("overflow");

        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00};
        send(pkt[0:2], 0);
        @(negedge clk);
        rx_tvalid = 1'b0;
        rst_n = 1'b0;
        chk_reset("reset_mid");
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        pkt = '{8'hD2};
        send(pkt, 0);
        exp_q.push_back(e_hs(4'h2, last_st + 1));
        idle(3);
        check("after_reset");

        for (int it = 0; it < 160; it++) begin
            bit gaps;
            gaps = 1'($urandom);
            build_random();
            pk2 = pkt;
            send(pk2, gaps);
            model(pk2, last_st);
            if ($urandom_range(0, 3) == 0) begin
                gen_token(4'h5, 11'($urandom), 0);
                send(pkt, 0);
                model(pkt, last_st);
            end
            idle(3);
            check($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
